anspwm_mc: RTL and testbench

//  Multi-channel noise-shaped PWM: per channel, truncates IN_W-bit target to OUT_W-bit duty with

---
 rtl/anspwm_mc.sv | 200 ++++++++++++++++++++
 tb/tb_anspwm_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/anspwm_mc.sv
// ---------------------------------------------------------------------------
// anspwm_mc : multi-channel noise-shaped PWM.
// Each channel truncates an IN_W-bit target to an OUT_W-bit duty once per PWM
// period. The truncation residue is fed back into the next period's sum, so
// the long-run mean duty tracks the full-precision target.
//
// Ports
//   clk          : clock
//   rst          : asynchronous, active-high reset
//   tgt_in       : CH targets, channel k at [k*IN_W +: IN_W]
//   tgt_valid    : tgt_in valid
//   tgt_ready    : one-entry input buffer is free
//   val_out      : current duty per channel, channel k at [k*OUT_W +: OUT_W]
//   pwm_out      : PWM outputs, high while cnt < duty
//   sat_out      : 1-cycle pulse, channel clamped at the last boundary
//   period_start : 1-cycle pulse on the first cycle of each period
//
// Build option
//   ANSPWM_ORDER2_EN : second-order error feedback (sum = held + 2*e1 - e2).
//                      Undefined: first-order feedback (sum = held + e1).
// ---------------------------------------------------------------------------
module anspwm_mc #(
   parameter int unsigned CH       = 4,
   parameter int unsigned IN_W     = 32,
   parameter int unsigned OUT_W    = 8,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CH*IN_W-1:0]   tgt_in,
   input  logic                 tgt_valid,
   output logic                 tgt_ready,
   output logic [CH*OUT_W-1:0]  val_out,
   output logic [CH-1:0]        pwm_out,
   output logic [CH-1:0]        sat_out,
   output logic                 period_start
);

   localparam int unsigned F   = IN_W - OUT_W;
   localparam int unsigned PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned S1W = IN_W + 1;
`ifdef ANSPWM_ORDER2_EN
   localparam int unsigned S2W = IN_W + 3;
`endif

   logic [PW-1:0]        presc_q, presc_d;
   logic [OUT_W-1:0]     cnt_q,   cnt_d;
   logic [CH*IN_W-1:0]   pend_q,  pend_d;
   logic                 rdy_q,   rdy_d;
   logic [CH*IN_W-1:0]   held_q,  held_d;
   logic [CH*F-1:0]      e1_q,    e1_d;
`ifdef ANSPWM_ORDER2_EN
   logic [CH*F-1:0]      e2_q,    e2_d;
`endif
   logic [CH*OUT_W-1:0]  val_q,   val_d;
   logic [CH-1:0]        pwm_q,   pwm_d;
   logic [CH-1:0]        sat_q,   sat_d;
   logic                 ps_q,    ps_d;

   logic                 tick_c;
   logic                 bnd_c;
   logic                 accept_c;
   logic [CH*IN_W-1:0]   src_c;
   logic [CH*OUT_W-1:0]  q_c;
   logic [CH*F-1:0]      e_c;
   logic [CH-1:0]        clamp_c;

   // Timebase and handshake; the buffer is full exactly when not ready.
   assign tick_c   = (presc_q == PW'(PRESCALE - 1));
   assign bnd_c    = tick_c && (cnt_q == '1);
   assign accept_c = tgt_valid && rdy_q;

   // Boundary source: a same-cycle accept bypasses the (empty) buffer,
   // otherwise a pending sample, otherwise the held target is reused.
   assign src_c = accept_c ? tgt_in : (!rdy_q ? pend_q : held_q);

   // Per-channel quantiser with residue feedback.
   always_comb begin
      logic [IN_W-1:0] src_k;
      logic [IN_W-1:0] sat_k;
`ifdef ANSPWM_ORDER2_EN
      logic signed [S2W-1:0] sum_k;
`else
      logic [S1W-1:0] sum_k;
`endif
      q_c     = '0;
      e_c     = '0;
      clamp_c = '0;
      src_k   = '0;
      sat_k   = '0;
      sum_k   = '0;
      for (int k = 0; k < CH; k++) begin
         src_k = src_c[k*IN_W +: IN_W];
`ifdef ANSPWM_ORDER2_EN
         sum_k = $signed(S2W'(src_k))
               + $signed(S2W'({e1_q[k*F +: F], 1'b0}))
               - $signed(S2W'(e2_q[k*F +: F]));
         // Negative clamps to zero, anything above 2^IN_W-1 to all-ones.
         if (sum_k[S2W-1]) begin
            sat_k      = '0;
            clamp_c[k] = 1'b1;
         end else if (|sum_k[IN_W+1:IN_W]) begin
            sat_k      = '1;
            clamp_c[k] = 1'b1;
         end else begin
            sat_k = sum_k[IN_W-1:0];
         end
`else
         sum_k      = S1W'(src_k) + S1W'(e1_q[k*F +: F]);
         clamp_c[k] = sum_k[IN_W];
         sat_k      = sum_k[IN_W] ? '1 : sum_k[IN_W-1:0];
`endif
         q_c[k*OUT_W +: OUT_W] = sat_k[IN_W-1 -: OUT_W];
         e_c[k*F +: F]         = sat_k[F-1:0];
      end
   end

   // Next-state: counters, input buffer, boundary loads, registered outputs.
   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      rdy_d   = rdy_q;
      held_d  = held_q;
      e1_d    = e1_q;
`ifdef ANSPWM_ORDER2_EN
      e2_d    = e2_q;
`endif
      val_d   = val_q;
      sat_d   = '0;
      ps_d    = 1'b0;
      pwm_d   = '0;

      if (tick_c) begin
         presc_d = '0;
         cnt_d   = cnt_q + OUT_W'(1);
      end else begin
         presc_d = presc_q + PW'(1);
      end

      if (bnd_c) begin
         rdy_d  = 1'b1;
         held_d = src_c;
         e1_d   = e_c;
`ifdef ANSPWM_ORDER2_EN
         e2_d   = e1_q;
`endif
         val_d  = q_c;
         sat_d  = clamp_c;
         ps_d   = 1'b1;
      end else if (accept_c) begin
         pend_d = tgt_in;
         rdy_d  = 1'b0;
      end

      // Compare against next-state count/duty so pwm_out lines up with cnt.
      for (int k = 0; k < CH; k++) begin
         pwm_d[k] = (cnt_d < val_d[k*OUT_W +: OUT_W]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         cnt_q   <= '0;
         pend_q  <= '0;
         rdy_q   <= 1'b1;
         held_q  <= '0;
         e1_q    <= '0;
`ifdef ANSPWM_ORDER2_EN
         e2_q    <= '0;
`endif
         val_q   <= '0;
         pwm_q   <= '0;
         sat_q   <= '0;
         ps_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         rdy_q   <= rdy_d;
         held_q  <= held_d;
         e1_q    <= e1_d;
`ifdef ANSPWM_ORDER2_EN
         e2_q    <= e2_d;
`endif
         val_q   <= val_d;
         pwm_q   <= pwm_d;
         sat_q   <= sat_d;
         ps_q    <= ps_d;
      end
   end

   assign tgt_ready    = rdy_q;
   assign val_out      = val_q;
   assign pwm_out      = pwm_q;
   assign sat_out      = sat_q;
   assign period_start = ps_q;

endmodule

// File: tb/tb_anspwm_mc.sv
`timescale 1ns/1ps
module tb_anspwm_mc;

   localparam int unsigned CH    = 4;
   localparam int unsigned IN_W  = 32;
   localparam int unsigned OUT_W = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [CH*IN_W-1:0]   tgt_in;
   logic                 tgt_valid;
   logic                 tgt_ready;
   logic [CH*OUT_W-1:0]  val_out;
   logic [CH-1:0]        pwm_out;
   logic [CH-1:0]        sat_out;
   logic                 period_start;

   logic [CH*IN_W-1:0]   tgt3_in;
   logic                 tgt3_valid;
   logic                 tgt3_ready;
   logic [CH*OUT_W-1:0]  val3_out;
   logic [CH-1:0]        pwm3_out;
   logic [CH-1:0]        sat3_out;
   logic                 period3_start;

   anspwm_mc #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .PRESCALE(1)) u_dut (
      .clk(clk), .rst(rst), .tgt_in(tgt_in), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
      .val_out(val_out), .pwm_out(pwm_out), .sat_out(sat_out), .period_start(period_start));

   anspwm_mc #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .PRESCALE(3)) u_dut3 (
      .clk(clk), .rst(rst), .tgt_in(tgt3_in), .tgt_valid(tgt3_valid), .tgt_ready(tgt3_ready),
      .val_out(val3_out), .pwm_out(pwm3_out), .sat_out(sat3_out), .period_start(period3_start));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH*OUT_W-1:0] val;
      logic [CH-1:0]       sat;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   pops     = 0;
   bit   done3    = 1'b0;

   // Hand-computed duties for boundaries 1..9.
   int d0[9] = '{'h80, 'h80, 'h80, 'h80, 'h80, 'h40, 'hC0, 'hC0, 'hC0};
   int d2[9] = '{'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF};
   int s2[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
`ifdef ANSPWM_ORDER2_EN
   int d1[9] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};
   int d3[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
`else
   int d1[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
   int d3[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
`endif

   localparam logic [CH*IN_W-1:0] S1 = {32'h0000_0000, 32'hFFFF_FFFF, 32'h0080_0000, 32'h8000_0000};
   localparam logic [CH*IN_W-1:0] SA = {32'h0040_0000, 32'hFFFF_FFFF, 32'h0080_0000, 32'h8000_0000};
   localparam logic [CH*IN_W-1:0] SB = {32'h0040_0000, 32'hFFFF_FFFF, 32'h0080_0000, 32'h4000_0000};
   localparam logic [CH*IN_W-1:0] SC = {32'h0040_0000, 32'hFFFF_FFFF, 32'h0080_0000, 32'hC000_0000};
   localparam logic [CH*IN_W-1:0] SD = {32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic push_b(input int i);
      exp_t e;
      e.val = {8'(d3[i]), 8'(d2[i]), 8'(d1[i]), 8'(d0[i])};
      e.sat = {1'b0, 1'(s2[i]), 2'b00};
      exp_q.push_back(e);
   endtask

   task automatic wait_ps(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_start && n < 600);
      if (!period_start) check(name, 64'd0, 64'd1);
   endtask

   // Monitor: pops one expectation per period start; checks duty, sat pulse,
   // and the pwm high-count of the period that just ended.
   initial begin : monitor
      int   cnt[CH];
      bit   have_prev;
      exp_t prev;
      exp_t cur;
      have_prev = 1'b0;
      prev      = '0;
      for (int k = 0; k < CH; k++) cnt[k] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            have_prev = 1'b0;
            for (int k = 0; k < CH; k++) cnt[k] = 0;
         end else begin
            if (period_start) begin
               if (have_prev) begin
                  for (int k = 0; k < CH; k++)
                     check($sformatf("pwm_count_ch%0d_p%0d", k, pops), 64'(cnt[k]),
                           64'(prev.val[k*OUT_W +: OUT_W]));
               end
               if (exp_q.size() == 0) begin
                  check("unexpected_period_start", 64'd1, 64'd0);
                  have_prev = 1'b0;
               end else begin
                  cur = exp_q.pop_front();
                  check($sformatf("val_out_p%0d", pops + 1), 64'(val_out), 64'(cur.val));
                  check($sformatf("sat_out_p%0d", pops + 1), 64'(sat_out), 64'(cur.sat));
                  prev      = cur;
                  have_prev = 1'b1;
               end
               pops++;
               for (int k = 0; k < CH; k++) cnt[k] = 0;
            end
            for (int k = 0; k < CH; k++) cnt[k] += int'(pwm_out[k]);
         end
      end
   end

   // PRESCALE=3 instance: duty 0x40 gives 768-clk period, 192 clks high.
   initial begin : presc3
      int n;
      int h;
      tgt3_in    = '0;
      tgt3_valid = 1'b0;
      #2;
      n = 0;
      while (rst && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      tgt3_in    = {96'd0, 32'h4000_0000};
      tgt3_valid = 1'b1;
      @(negedge clk);
      tgt3_valid = 1'b0;
      n = 0;
      while (!period3_start && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("p3_first_period_start", 64'(period3_start), 64'd1);
      check("p3_val_out_ch0", 64'(val3_out[7:0]), 64'h40);
      n = 0;
      h = 0;
      do begin
         h += int'(pwm3_out[0]);
         n++;
         @(negedge clk);
      end while (!period3_start && n < 2000);
      check("p3_period_clks", 64'(n), 64'd768);
      check("p3_pwm_high_clks", 64'(h), 64'd192);
      done3 = 1'b1;
   end

   initial begin : stim
      int n;
      tgt_in    = '0;
      tgt_valid = 1'b0;
      rst       = 1'b0;
      #1 rst    = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_val_out", 64'(val_out), 64'd0);
      check("reset_pwm_out", 64'(pwm_out), 64'd0);
      check("reset_sat_out", 64'(sat_out), 64'd0);
      check("reset_period_start", 64'(period_start), 64'd0);
      check("reset_tgt_ready", 64'(tgt_ready), 64'd1);
      rst = 1'b0;

      // S1 mid period 0: applied at boundaries 1..4.
      repeat (20) @(negedge clk);
      push_b(0); push_b(1); push_b(2); push_b(3);
      tgt_in    = S1;
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      check("ready_low_after_accept", 64'(tgt_ready), 64'd0);
      repeat (4) wait_ps("wait_p1_to_p4");

      // A then B back-to-back mid P4: A at boundary 5, B stalls to P5, applied at 6.
      repeat (50) @(negedge clk);
      push_b(4); push_b(5);
      tgt_in    = SA;
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_in    = SB;
      check("ready_low_b_stalls", 64'(tgt_ready), 64'd0);
      n = 0;
      while (!tgt_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("b_accepted_at_period_start", 64'(period_start), 64'd1);
      @(negedge clk);
      tgt_valid = 1'b0;

      // Bypass: C presented on the boundary cycle of P6.
      wait_ps("wait_p6");
      repeat (255) @(negedge clk);
      push_b(6); push_b(7); push_b(8);
      tgt_in    = SC;
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      check("bypass_boundary_hit", 64'(period_start), 64'd1);
      check("bypass_ready_stays_high", 64'(tgt_ready), 64'd1);
      wait_ps("wait_p8");
      wait_ps("wait_p9");

      // Reset mid P9 with a pending sample and pwm active.
      repeat (50) @(negedge clk);
      tgt_in    = SD;
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      check("pend_full_before_reset", 64'(tgt_ready), 64'd0);
      check("pwm_active_before_reset", 64'(pwm_out), 64'b0101);
      n = 0;
      while (!done3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("presc3_done", 64'(done3), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_val_out", 64'(val_out), 64'd0);
      check("async_reset_pwm_out", 64'(pwm_out), 64'd0);
      check("async_reset_sat_out", 64'(sat_out), 64'd0);
      check("async_reset_period_start", 64'(period_start), 64'd0);
      check("async_reset_tgt_ready", 64'(tgt_ready), 64'd1);
      @(negedge clk);
      exp_q.push_back('0);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_start && n < 600);
      check("post_reset_first_boundary_clks", 64'(n), 64'd256);
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("periods_observed", 64'(pops), 64'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
